// File: rtl/apb_uart_pkg.sv
// Shared types and constants for the APB UART initiator: FSM states,
// command op encodings, UART register map and STATUS bit positions.
package apb_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_POLL  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  localparam logic [4:0] ADDR_TXDATA = 5'h00;
  localparam logic [4:0] ADDR_RXDATA = 5'h04;
  localparam logic [4:0] ADDR_CTRL1  = 5'h08;
  localparam logic [4:0] ADDR_CTRL2  = 5'h0C;
  localparam logic [4:0] ADDR_STATUS = 5'h10;
  localparam logic [4:0] ADDR_CTRL3  = 5'h14;

  localparam int STAT_TXRDY       = 0;
  localparam int STAT_RXRDY       = 1;
  localparam int STAT_PARITY_ERR  = 2;
  localparam int STAT_OVERFLOW    = 3;
  localparam int STAT_FRAMING_ERR = 4;

endpackage

// File: rtl/apb_init_wdog.sv
// Wait-state and poll-read counters for the APB initiator; reports when the
// wait limit is reached and when the current poll read is the last allowed one.
module apb_init_wdog #(
  parameter int WAIT_LIMIT = 15,
  parameter int POLL_LIMIT = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_wait_clr,
  input  logic i_wait_inc,
  input  logic i_poll_clr,
  input  logic i_poll_inc,
  output logic o_wait_hit,
  output logic o_poll_last
);

  logic [7:0]  r_wait_cnt;
  logic [15:0] r_poll_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wait_cnt <= 8'd0;
      r_poll_cnt <= 16'd0;
    end else begin
      if (i_wait_clr)
        r_wait_cnt <= 8'd0;
      else if (i_wait_inc && !o_wait_hit)
        r_wait_cnt <= r_wait_cnt + 8'd1;

      if (i_poll_clr)
        r_poll_cnt <= 16'd0;
      else if (i_poll_inc && !o_poll_last)
        r_poll_cnt <= r_poll_cnt + 16'd1;
    end
  end

  assign o_wait_hit  = (r_wait_cnt == 8'(WAIT_LIMIT));
  // Counts completed reads, so the read in flight is number r_poll_cnt+1.
  assign o_poll_last = (r_poll_cnt == 16'(POLL_LIMIT - 1));

endmodule

// File: rtl/apb_uart_initiator.sv
// Command-driven APB initiator for a UART register block: single read, single
// write, or STATUS polling until a masked bit sets, with wait-state timeout.
module apb_uart_initiator
  import apb_uart_pkg::*;
#(
  parameter int WAIT_LIMIT = 15,
  parameter int POLL_LIMIT = 255
) (
  input  logic       i_pclk,
  input  logic       i_presetn,
  // Both handshakes: a transfer happens on the rising edge where valid and
  // ready are high together; valid-side payload must hold until then.
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic [1:0] i_cmd_op,
  input  logic [4:0] i_cmd_addr,
  input  logic [7:0] i_cmd_wdata,
  output logic       o_rsp_valid,
  input  logic       i_rsp_ready,
  output logic [7:0] o_rsp_rdata,
  output logic       o_rsp_err,
  output logic [4:0] o_paddr,
  output logic       o_psel,
  output logic       o_penable,
  output logic       o_pwrite,
  output logic [7:0] o_pwdata,
  input  logic [7:0] i_prdata,
  input  logic       i_pready,
  input  logic       i_pslverr,
  output logic [1:0] o_state
);

  state_e     r_state;
  state_e     w_next;
  op_e        r_op;
  logic [4:0] r_addr;
  logic [7:0] r_wdata;
  logic [7:0] r_rsp_rdata;
  logic       r_rsp_err;

  logic w_accept, w_done, w_tmo, w_hit, w_poll_more;
  logic w_wait_hit, w_poll_last;

  assign w_accept    = i_cmd_valid && o_cmd_ready;
  assign w_done      = (r_state == ST_ACCESS) && i_pready;
  assign w_tmo       = (r_state == ST_ACCESS) && !i_pready && w_wait_hit;
  assign w_hit       = |(i_prdata & r_wdata);
  assign w_poll_more = (r_op == OP_POLL) && !w_hit && !i_pslverr && !w_poll_last;

  apb_init_wdog #(
    .WAIT_LIMIT(WAIT_LIMIT),
    .POLL_LIMIT(POLL_LIMIT)
  ) u_wdog (
    .i_clk      (i_pclk),
    .i_rst_n    (i_presetn),
    .i_wait_clr (r_state == ST_SETUP),
    .i_wait_inc ((r_state == ST_ACCESS) && !i_pready),
    .i_poll_clr (w_accept),
    .i_poll_inc (w_done && (r_op == OP_POLL)),
    .o_wait_hit (w_wait_hit),
    .o_poll_last(w_poll_last)
  );

  always_ff @(posedge i_pclk) begin
    if (!i_presetn) r_state <= ST_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_next = (i_cmd_op == OP_RSVD) ? ST_RESP : ST_SETUP;
      ST_SETUP:  w_next = ST_ACCESS;
      ST_ACCESS: begin
        if (i_pready)        w_next = w_poll_more ? ST_SETUP : ST_RESP;
        else if (w_wait_hit) w_next = ST_RESP;
      end
      ST_RESP:   if (i_rsp_ready) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_cmd_ready = 1'b0;
    o_rsp_valid = 1'b0;
    o_psel      = 1'b0;
    o_penable   = 1'b0;
    o_paddr     = 5'd0;
    o_pwrite    = 1'b0;
    o_pwdata    = 8'd0;
    case (r_state)
      ST_IDLE: o_cmd_ready = 1'b1;
      ST_SETUP, ST_ACCESS: begin
        o_psel    = 1'b1;
        o_penable = (r_state == ST_ACCESS);
        o_paddr   = (r_op == OP_POLL) ? ADDR_STATUS : r_addr;
        o_pwrite  = (r_op == OP_WRITE);
        o_pwdata  = (r_op == OP_WRITE) ? r_wdata : 8'd0;
      end
      ST_RESP: o_rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_pclk) begin
    if (!i_presetn) begin
      r_op        <= OP_READ;
      r_addr      <= 5'd0;
      r_wdata     <= 8'd0;
      r_rsp_rdata <= 8'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op    <= op_e'(i_cmd_op);
        r_addr  <= i_cmd_addr;
        r_wdata <= i_cmd_wdata;
        if (i_cmd_op == OP_RSVD) begin
          r_rsp_rdata <= 8'd0;
          r_rsp_err   <= 1'b1;
        end
      end
      if (w_done) begin
        case (r_op)
          OP_READ:  begin r_rsp_rdata <= i_prdata; r_rsp_err <= i_pslverr; end
          OP_WRITE: begin r_rsp_rdata <= 8'd0;     r_rsp_err <= i_pslverr; end
          // Exhausting the poll budget without a hit is reported as an error.
          default:  begin
            r_rsp_rdata <= i_prdata;
            r_rsp_err   <= i_pslverr || (!w_hit && w_poll_last);
          end
        endcase
      end else if (w_tmo) begin
        r_rsp_rdata <= 8'd0;
        r_rsp_err   <= 1'b1;
      end
    end
  end

  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;
  assign o_state     = r_state;

endmodule

// File: tb/tb_apb_uart_initiator.sv
// Bench for apb_uart_initiator: directed vector table, hand-written timing
// and reset sequences, and random commands against a planned APB responder.
module tb_apb_uart_initiator;
  import apb_uart_pkg::*;

  localparam int WL = 15;
  localparam int PL = 6;

  logic       clk, presetn;
  logic       cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err;
  logic [1:0] cmd_op, state;
  logic [4:0] cmd_addr, paddr;
  logic [7:0] cmd_wdata, rsp_rdata, pwdata, prdata;
  logic       psel, penable, pwrite, pready, pslverr;

  apb_uart_initiator #(.WAIT_LIMIT(WL), .POLL_LIMIT(PL)) dut (
    .i_pclk(clk), .i_presetn(presetn),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_op(cmd_op),
    .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
    .o_paddr(paddr), .o_psel(psel), .o_penable(penable), .o_pwrite(pwrite),
    .o_pwdata(pwdata), .i_prdata(prdata), .i_pready(pready),
    .i_pslverr(pslverr), .o_state(state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Planned responder behaviour: per transfer, ACCESS cycles with PREADY low,
  // then the data and error returned.
  int         plan_wait_q[$];
  logic [7:0] plan_data_q[$];
  logic       plan_err_q[$];

  int         slv_cnt = 0;
  bit         prev_access = 0, prev_psel = 0, seen_psel = 0;
  int         n_setup = 0, n_access = 0, psel_gaps = 0, proto_err = 0;
  logic [4:0] last_paddr = '0;
  logic       last_pwrite = 1'b0;
  logic [7:0] last_pwdata = '0;

  always @(posedge clk) begin
    #2;
    if (prev_access && !(psel && penable) && plan_wait_q.size() > 0) begin
      void'(plan_wait_q.pop_front());
      void'(plan_data_q.pop_front());
      void'(plan_err_q.pop_front());
    end
    if (psel && !penable) begin
      n_setup++;
      last_paddr  = paddr;
      last_pwrite = pwrite;
      last_pwdata = pwdata;
    end
    if (psel && penable) begin
      n_access++;
      if (paddr !== last_paddr || pwrite !== last_pwrite || pwdata !== last_pwdata) proto_err++;
      if (plan_wait_q.size() == 0) begin
        pready = 1'b1; prdata = 8'h00; pslverr = 1'b0;
      end else if (slv_cnt >= plan_wait_q[0]) begin
        pready = 1'b1; prdata = plan_data_q[0]; pslverr = plan_err_q[0];
      end else begin
        pready = 1'b0; prdata = 8'($urandom); pslverr = 1'b0;
      end
      slv_cnt++;
    end else begin
      slv_cnt = 0; pready = 1'b0; prdata = 8'h00; pslverr = 1'b0;
    end
    if (penable && !psel) proto_err++;
    if (rsp_valid && psel) proto_err++;
    if (psel && !prev_psel && seen_psel) psel_gaps++;
    if (psel) seen_psel = 1;
    prev_psel   = psel;
    prev_access = psel && penable;
  end

  task automatic plan(input int w, input logic [7:0] d, input logic e);
    plan_wait_q.push_back(w);
    plan_data_q.push_back(d);
    plan_err_q.push_back(e);
  endtask

  // Driver: issue one command, wait for the response, hold RSP_READY low for
  // dly cycles while checking the response stays put.
  task automatic run_cmd(input logic [1:0] op, input logic [4:0] addr, input logic [7:0] wd,
                         input int dly, output logic [7:0] rd, output logic er);
    int cyc;
    bit stable;
    n_setup = 0; n_access = 0; psel_gaps = 0; seen_psel = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wd;
    cyc = 0;
    while (!cmd_ready && cyc < 50) begin step(); cyc++; end
    step();
    cmd_valid = 1'b0;
    cyc = 0;
    while (!rsp_valid && cyc < 2000) begin step(); cyc++; end
    rd = rsp_rdata;
    er = rsp_err;
    if (!rsp_valid) begin
      check("rsp_timeout", 32'(rsp_valid), 32'd1);
    end else begin
      stable = 1;
      for (int i = 0; i < dly; i++) begin
        step();
        if (!rsp_valid || rsp_rdata !== rd || rsp_err !== er || cmd_ready) stable = 0;
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      check("rsp_hold", 32'(stable), 32'd1);
      check("rsp_done_idle", {rsp_valid, cmd_ready}, 32'b01);
    end
  endtask

  // Reference model: outcome of a command from the planned transfers.
  int         m_wt[PL];
  logic [7:0] m_pd[PL];
  logic       m_pe[PL];

  task automatic model(input logic [1:0] op, input logic [7:0] mask,
                       output logic [7:0] rd, output logic er, output int nx);
    bit done;
    rd = 8'h00; er = 1'b0; nx = 0; done = 0;
    if (op == 2'b11) begin
      er = 1'b1;
    end else if (op != 2'b10) begin
      nx = 1;
      if (m_wt[0] > WL) er = 1'b1;
      else begin
        rd = (op == 2'b00) ? m_pd[0] : 8'h00;
        er = m_pe[0];
      end
    end else begin
      for (int k = 0; k < PL && !done; k++) begin
        nx = k + 1;
        if (m_wt[k] > WL) begin rd = 8'h00; er = 1'b1; done = 1; end
        else if ((m_pd[k] & mask) != 0 || m_pe[k]) begin rd = m_pd[k]; er = m_pe[k]; done = 1; end
        else if (k + 1 == PL) begin rd = m_pd[k]; er = 1'b1; done = 1; end
      end
    end
  endtask

  typedef struct {
    logic [1:0] op; logic [4:0] addr; logic [7:0] wd; int wt; logic [7:0] pd; logic pe;
    int dly; logic [7:0] exp_rd; logic exp_er; int exp_xfers; int exp_access;
  } vec_t;

  vec_t       tbl[8];
  logic [8:0] exp_q[$];
  logic [4:0] regs[6];

  initial begin
    logic [7:0] rd, erd;
    logic       er, eer;
    logic [8:0] e;
    logic [1:0] op;
    logic [4:0] addr;
    logic [7:0] wd;
    int         nx, r, cnt;

    tbl[0] = '{2'b01, 5'h08, 8'h5A, 0,  8'h00, 1'b0, 0, 8'h00, 1'b0, 1, 1};
    tbl[1] = '{2'b00, 5'h04, 8'h00, 3,  8'hC3, 1'b0, 0, 8'hC3, 1'b0, 1, 4};
    tbl[2] = '{2'b00, 5'h0C, 8'h00, 15, 8'h77, 1'b0, 2, 8'h77, 1'b0, 1, 16};
    tbl[3] = '{2'b00, 5'h00, 8'h00, 16, 8'h55, 1'b0, 0, 8'h00, 1'b1, 1, 16};
    tbl[4] = '{2'b01, 5'h14, 8'h3C, 1,  8'h00, 1'b1, 5, 8'h00, 1'b1, 1, 2};
    tbl[5] = '{2'b11, 5'h08, 8'hFF, 0,  8'h00, 1'b0, 1, 8'h00, 1'b1, 0, 0};
    tbl[6] = '{2'b10, 5'h00, 8'h01, 2,  8'h81, 1'b0, 0, 8'h81, 1'b0, 1, 3};
    tbl[7] = '{2'b00, 5'h10, 8'h00, 0,  8'h9E, 1'b1, 3, 8'h9E, 1'b1, 1, 1};
    regs = '{ADDR_TXDATA, ADDR_RXDATA, ADDR_CTRL1, ADDR_CTRL2, ADDR_STATUS, ADDR_CTRL3};

    presetn = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; pready = 1'b0; prdata = '0; pslverr = 1'b0;
    repeat (3) step();
    check("reset_apb", {paddr, psel, penable, pwrite, pwdata}, 32'd0);
    check("reset_rsp", {rsp_valid, rsp_rdata, rsp_err}, 32'd0);
    check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    presetn = 1'b1;
    step();
    check("idle_state", {state, cmd_ready}, {30'(ST_IDLE), 1'b1});

    // Directed vectors
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].op != 2'b11) plan(tbl[i].wt, tbl[i].pd, tbl[i].pe);
      run_cmd(tbl[i].op, tbl[i].addr, tbl[i].wd, tbl[i].dly, rd, er);
      check($sformatf("vec%0d_rdata", i), 32'(rd), 32'(tbl[i].exp_rd));
      check($sformatf("vec%0d_err", i), 32'(er), 32'(tbl[i].exp_er));
      check($sformatf("vec%0d_xfers", i), n_setup, tbl[i].exp_xfers);
      check($sformatf("vec%0d_access", i), n_access, tbl[i].exp_access);
    end

    // Write timing: SETUP, then ACCESS with payload, then response
    plan(0, 8'h00, 1'b0);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 5'h08; cmd_wdata = 8'h5A;
    step();
    cmd_valid = 1'b0;
    check("wr_setup", {psel, penable, cmd_ready}, 32'b100);
    step();
    check("wr_access", {psel, penable, pwrite, paddr, pwdata}, {19'd0, 3'b111, 5'h08, 8'h5A});
    step();
    check("wr_resp", {rsp_valid, rsp_err, psel}, 32'b100);
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;

    // Poll until RXRDY: two misses then a hit, back-to-back
    plan(0, 8'h01, 1'b0); plan(1, 8'h01, 1'b0); plan(0, 8'h03, 1'b0);
    run_cmd(2'b10, 5'h04, 8'h02, 0, rd, er);
    check("poll_rdata", {er, rd}, {1'b0, 8'h03});
    check("poll_xfers", n_setup, 3);
    check("poll_psel_gaps", psel_gaps, 0);
    check("poll_paddr", {last_pwrite, last_paddr}, {1'b0, ADDR_STATUS});

    // Reset in the middle of ACCESS drops the command silently
    plan(50, 8'hAA, 1'b0);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 5'h04; cmd_wdata = 8'h00;
    step(); cmd_valid = 1'b0;
    step(); step();
    check("pre_reset_access", {psel, penable}, 32'b11);
    presetn = 1'b0;
    step();
    check("mid_reset", {psel, penable, rsp_valid, cmd_ready}, 32'b0001);
    presetn = 1'b1;
    plan_wait_q.delete(); plan_data_q.delete(); plan_err_q.delete();
    cnt = 0;
    for (int i = 0; i < 30; i++) begin step(); if (rsp_valid) cnt++; end
    check("no_rsp_after_reset", cnt, 0);

    // Poll with mask 0 exhausts the budget
    for (int k = 0; k < PL; k++) begin
      m_wt[k] = $urandom_range(0, 2); m_pd[k] = 8'($urandom); m_pe[k] = 1'b0;
      plan(m_wt[k], m_pd[k], m_pe[k]);
    end
    run_cmd(2'b10, 5'h00, 8'h00, 0, rd, er);
    check("poll_exhaust", {er, rd}, {1'b1, m_pd[PL-1]});
    check("poll_exhaust_xfers", n_setup, PL);

    // Random commands against the reference model
    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 9);
      op = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      addr = regs[$urandom_range(0, 5)];
      wd = 8'($urandom);
      if (op == 2'b10) wd = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'(1 << $urandom_range(0, 4));
      for (int k = 0; k < PL; k++) begin
        m_wt[k] = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 3);
        m_pd[k] = 8'($urandom) & 8'h1F;
        m_pe[k] = ($urandom_range(0, 9) == 0);
      end
      model(op, wd, erd, eer, nx);
      for (int k = 0; k < nx; k++) plan(m_wt[k], m_pd[k], m_pe[k]);
      exp_q.push_back({eer, erd});
      run_cmd(op, addr, wd, $urandom_range(0, 3), rd, er);
      e = exp_q.pop_front();
      check($sformatf("rand%0d_rdata", t), 32'(rd), 32'(e[7:0]));
      check($sformatf("rand%0d_err", t), 32'(er), 32'(e[8]));
      check($sformatf("rand%0d_xfers", t), n_setup, nx);
      if (nx > 0)
        check($sformatf("rand%0d_paddr", t), 32'(last_paddr), (op == 2'b10) ? 32'(ADDR_STATUS) : 32'(addr));
      if (op == 2'b01)
        check($sformatf("rand%0d_pwdata", t), {last_pwrite, last_pwdata}, {1'b1, wd});
    end

    check("protocol_violations", proto_err, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
